// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SZ_*        funct3 access-size encodings
//   state_e     FSM states of the load/store unit
//   exc_cause_e exception cause codes reported on exc_cause
//   be_mask()   unshifted byte-enable pattern for an access size
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_D  = 3'b011;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;
    localparam logic [2:0] SZ_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        EXC_MISALIGN = 2'd0,
        EXC_ILLEGAL  = 2'd1,
        EXC_TIMEOUT  = 2'd2
    } exc_cause_e;

    // The low two funct3 bits give the access width; the unsigned bit
    // does not change how many bytes are touched.
    function automatic logic [7:0] be_mask(input logic [2:0] size);
        case (size[1:0])
            2'b00:   be_mask = 8'h01;
            2'b01:   be_mask = 8'h03;
            2'b10:   be_mask = 8'h0F;
            default: be_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   size     : funct3 access size
//   off      : byte offset of the access inside the XLEN-wide bus word
//   st_data  : rs2 value for stores
//   ld_raw   : raw bus read word
//   be       : byte enables (size mask shifted to the lane offset)
//   st_lanes : store data replicated into every lane of its width
//   ld_data  : selected lane, sign- or zero-extended to XLEN
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                size,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [XLEN-1:0]           st_data,
    input  logic [XLEN-1:0]           ld_raw,
    output logic [XLEN/8-1:0]         be,
    output logic [XLEN-1:0]           st_lanes,
    output logic [XLEN-1:0]           ld_data
);
    localparam int NB = XLEN / 8;

    assign be = NB'(16'(be_mask(size)) << off);

    // Replicating the store value means the byte enables alone decide
    // which lanes land; no data shifter is needed.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign st_lanes[8*i +: 8] =
            (size[1:0] == 2'b00) ? st_data[7:0] :
            (size[1:0] == 2'b01) ? st_data[8*(i%2) +: 8] :
            (size[1:0] == 2'b10) ? st_data[8*(i%4) +: 8] :
                                   st_data[8*i +: 8];
    end

    logic [XLEN-1:0] shifted;
    assign shifted = ld_raw >> {off, 3'b000};

    always_comb begin
        case (size)
            SZ_B:    ld_data = XLEN'($signed(shifted[7:0]));
            SZ_H:    ld_data = XLEN'($signed(shifted[15:0]));
            SZ_W:    ld_data = XLEN'($signed(shifted[31:0]));
            SZ_BU:   ld_data = XLEN'(shifted[7:0]);
            SZ_HU:   ld_data = XLEN'(shifted[15:0]);
            SZ_WU:   ld_data = XLEN'(shifted[31:0]);
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/ieu_lsu.sv
// Multi-cycle load/store execution unit.
//   i_clk, i_rst        : clock, synchronous active-low reset
//   issue_*             : op handshake (valid/ready) and operands
//   mem_*               : req/gnt/rvalid data-memory bus
//   wb_valid/rd/data    : one-cycle load writeback pulse
//   exc_valid/exc_cause : one-cycle exception pulse (misalign/illegal/timeout)
//   op_done             : one-cycle pulse on every completion
// ADDR_W is expected to be no wider than XLEN.
module ieu_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic                issue_store,
    input  logic [2:0]          issue_size,
    input  logic [XLEN-1:0]     issue_base,
    input  logic [XLEN-1:0]     issue_imm,
    input  logic [XLEN-1:0]     issue_wdata,
    input  logic [4:0]          issue_rd,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                exc_valid,
    output logic [1:0]          exc_cause,
    output logic                op_done
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_e             state;
    logic [2:0]         size_q;
    logic               store_q;
    logic [4:0]         rd_q;
    logic [OFF_W-1:0]   off_q;
    logic [15:0]        tmo_cnt;

    logic [ADDR_W-1:0]  ea;
    logic               illegal, misal, tmo_hit;
    logic [2:0]         al_size;
    logic [OFF_W-1:0]   al_off;
    logic [NB-1:0]      al_be;
    logic [XLEN-1:0]    al_st, al_ld;

    assign ea      = ADDR_W'(issue_base + issue_imm);
    assign tmo_hit = tmo_cnt >= 16'(TIMEOUT - 1);

    // One aligner serves both directions: store steering is only needed
    // at accept (IDLE), load extraction only afterwards.
    assign al_size = (state == IDLE) ? issue_size : size_q;
    assign al_off  = (state == IDLE) ? ea[OFF_W-1:0] : off_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .size     (al_size),
        .off      (al_off),
        .st_data  (issue_wdata),
        .ld_raw   (mem_rdata),
        .be       (al_be),
        .st_lanes (al_st),
        .ld_data  (al_ld)
    );

    always_comb begin
        illegal = 1'b0;
        misal   = 1'b0;
        case (issue_size)
            SZ_B, SZ_H, SZ_W: illegal = 1'b0;
            SZ_BU, SZ_HU:     illegal = issue_store;
            SZ_WU:            illegal = issue_store || (XLEN == 32);
            SZ_D:             illegal = (XLEN == 32);
            default:          illegal = 1'b1;
        endcase
        case (issue_size)
            SZ_H, SZ_HU: misal = ea[0];
            SZ_W, SZ_WU: misal = (ea[1:0] != 2'b00);
            SZ_D:        misal = (ea[2:0] != 3'b000);
            default:     misal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= IDLE;
            issue_ready <= 1'b1;
            size_q      <= '0;
            store_q     <= 1'b0;
            rd_q        <= '0;
            off_q       <= '0;
            tmo_cnt     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= '0;
            mem_wdata   <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            exc_valid   <= 1'b0;
            exc_cause   <= '0;
            op_done     <= 1'b0;
        end else begin
            // Completion outputs are pulses; they only live in RESP.
            op_done   <= 1'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_cause <= '0;

            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        issue_ready <= 1'b0;
                        size_q      <= issue_size;
                        store_q     <= issue_store;
                        rd_q        <= issue_rd;
                        off_q       <= ea[OFF_W-1:0];
                        tmo_cnt     <= '0;
                        if (illegal || misal) begin
                            state     <= RESP;
                            op_done   <= 1'b1;
                            exc_valid <= 1'b1;
                            exc_cause <= illegal ? EXC_ILLEGAL : EXC_MISALIGN;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= issue_store;
                            mem_addr  <= {ea[ADDR_W-1:OFF_W], OFF_W'(0)};
                            mem_be    <= al_be;
                            mem_wdata <= al_st;
                        end
                    end
                end

                REQ: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem_gnt || tmo_hit) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                    end
                    // A grant in the last allowed cycle still wins over timeout.
                    if (mem_gnt) begin
                        if (store_q) begin
                            state   <= RESP;
                            op_done <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else if (tmo_hit) begin
                        state     <= RESP;
                        op_done   <= 1'b1;
                        exc_valid <= 1'b1;
                        exc_cause <= EXC_TIMEOUT;
                    end
                end

                WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (mem_rvalid) begin
                        state   <= RESP;
                        op_done <= 1'b1;
                        // x0 is never written, so no writeback pulse for rd=0.
                        if (rd_q != 5'd0) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= al_ld;
                        end
                    end else if (tmo_hit) begin
                        state     <= RESP;
                        op_done   <= 1'b1;
                        exc_valid <= 1'b1;
                        exc_cause <= EXC_TIMEOUT;
                    end
                end

                default: begin  // RESP
                    state       <= IDLE;
                    issue_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
